// File: rtl/proc_bus_pkg.sv
// Shared definitions for the processor load/store bus and its memory-side responder.
package proc_bus_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;
endpackage

// File: rtl/proc_mem_responder_if.sv
// Load/store request/response bundle between the processor and the memory responder.
interface proc_mem_responder_if
  import proc_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              req_in;
  logic              we_in;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata_in;
  logic [DATA_W-1:0] rdata_out;
  logic              ack_out;
  logic              err_out;
  logic              busy_out;

  modport master (
    output req_in, we_in, addr_in, wdata_in,
    input  rdata_out, ack_out, err_out, busy_out
  );

  modport slave (
    input  req_in, we_in, addr_in, wdata_in,
    output rdata_out, ack_out, err_out, busy_out
  );
endinterface

// File: rtl/proc_mem_array.sv
// Single-port synchronous RAM; dout is registered and returns to zero on any edge without a read.
module proc_mem_array #(
  parameter int DEPTH  = 200,
  parameter int DATA_W = 8,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately left without reset.
  always_ff @(posedge clk_in) begin
    if (en && we) mem[addr] <= din;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)         dout <= '0;
    else if (en && !we)  dout <= mem[addr];
    else                 dout <= '0;
  end
endmodule

// File: rtl/proc_mem_responder.sv
// Memory-side responder: captures one request, inserts WAIT_CYCLES wait states, then acks for one cycle.
module proc_mem_responder
  import proc_bus_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 200,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  proc_mem_responder_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ack_q, err_q, busy_q;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;
  logic              mem_en;
  logic [DATA_W-1:0] mem_dout;

  // With zero wait states the store is accessed on the capture edge, so the live inputs are used.
  always_comb begin
    sel_we    = (state_q == IDLE) ? bus.we_in    : we_q;
    sel_addr  = (state_q == IDLE) ? bus.addr_in  : addr_q;
    sel_wdata = (state_q == IDLE) ? bus.wdata_in : wdata_q;
    in_range  = 32'(sel_addr) < DEPTH_U;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req_in) begin
          cnt_d   = CNT_LOAD;
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mem_en = (state_d == RESP) && in_range;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && bus.req_in) begin
        we_q    <= bus.we_in;
        addr_q  <= bus.addr_in;
        wdata_q <= bus.wdata_in;
      end
      ack_q  <= (state_d == RESP);
      err_q  <= (state_d == RESP) && !in_range;
      busy_q <= (state_d != IDLE);
    end
  end

  proc_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .en     (mem_en),
    .we     (sel_we),
    .addr   (sel_addr[IDX_W-1:0]),
    .din    (sel_wdata),
    .dout   (mem_dout)
  );

  assign bus.rdata_out = mem_dout;
  assign bus.ack_out   = ack_q;
  assign bus.err_out   = err_q;
  assign bus.busy_out  = busy_q;
endmodule

// File: tb/tb_proc_mem_responder.sv
// Bench for proc_mem_responder: one instance with two wait states, one with none, checked against a transaction model.
module tb_proc_mem_responder;
  localparam int DEPTH = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req [2];
  logic       we [2];
  logic [7:0] addr [2];
  logic [7:0] wdata [2];
  logic       ack [2];
  logic       err [2];
  logic       busy [2];
  logic [7:0] rdata [2];

  proc_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
  proc_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();

  assign bus0.req_in   = req[0];
  assign bus0.we_in    = we[0];
  assign bus0.addr_in  = addr[0];
  assign bus0.wdata_in = wdata[0];
  assign bus1.req_in   = req[1];
  assign bus1.we_in    = we[1];
  assign bus1.addr_in  = addr[1];
  assign bus1.wdata_in = wdata[1];
  assign ack[0]   = bus0.ack_out;
  assign err[0]   = bus0.err_out;
  assign busy[0]  = bus0.busy_out;
  assign rdata[0] = bus0.rdata_out;
  assign ack[1]   = bus1.ack_out;
  assign err[1]   = bus1.err_out;
  assign busy[1]  = bus1.busy_out;
  assign rdata[1] = bus1.rdata_out;

  proc_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u_w2 (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus0)
  );

  proc_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus1)
  );

  int checks = 0;
  int failures = 0;

  function automatic int wc(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%0h expected=%0h", name, i, $time, got, exp);
    end
  endtask

  // Transaction model: a request seen while idle completes WAIT_CYCLES edges later,
  // and the next request can be taken two edges after that.
  int         ec = 0;
  bit         has_tx [2];
  int         cap_e [2];
  int         ack_e [2];
  bit         p_we [2];
  bit         p_err [2];
  logic [7:0] p_addr [2];
  logic [7:0] p_wd [2];
  logic [7:0] p_rd [2];
  logic [7:0] mem_m [2][256];
  bit         e_ack [2];
  bit         e_err [2];
  bit         e_busy [2];
  logic [7:0] e_rd [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      has_tx[i] = 0; cap_e[i] = 0; ack_e[i] = 0;
      e_ack[i] = 0; e_err[i] = 0; e_busy[i] = 0; e_rd[i] = 8'h00;
    end
    forever begin
      @(posedge clk);
      ec++;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          has_tx[i] = 0;
        end else begin
          if ((!has_tx[i] || ec >= ack_e[i] + 2) && req[i]) begin
            has_tx[i] = 1;
            cap_e[i]  = ec;
            ack_e[i]  = ec + wc(i);
            p_we[i]   = we[i];
            p_addr[i] = addr[i];
            p_wd[i]   = wdata[i];
            p_err[i]  = (int'(addr[i]) >= DEPTH);
          end
          if (has_tx[i] && ec == ack_e[i]) begin
            if (p_we[i] && !p_err[i]) mem_m[i][p_addr[i]] = p_wd[i];
            p_rd[i] = (p_we[i] || p_err[i]) ? 8'h00 : mem_m[i][p_addr[i]];
          end
        end
        e_ack[i]  = rst_n && has_tx[i] && ec == ack_e[i];
        e_err[i]  = e_ack[i] && p_err[i];
        e_rd[i]   = e_ack[i] ? p_rd[i] : 8'h00;
        e_busy[i] = rst_n && has_tx[i] && ec >= cap_e[i] && ec <= ack_e[i];
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk("ack",   i, 32'(ack[i]),   rst_n ? 32'(e_ack[i])  : 32'd0);
        chk("err",   i, 32'(err[i]),   rst_n ? 32'(e_err[i])  : 32'd0);
        chk("busy",  i, 32'(busy[i]),  rst_n ? 32'(e_busy[i]) : 32'd0);
        chk("rdata", i, 32'(rdata[i]), rst_n ? 32'(e_rd[i])   : 32'd0);
      end
    end
  end

  task automatic txn(input int i, input logic w, input logic [7:0] a, input logic [7:0] d,
                     output logic [7:0] rd, output logic er, output int lat);
    lat = -1; rd = 8'h00; er = 1'b0;
    @(negedge clk);
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
    @(posedge clk);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ack[i] === 1'b1) begin
        lat = n + 1; rd = rdata[i]; er = err[i];
        break;
      end
    end
    req[i] = 1'b0;
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL ack_timeout dut%0d addr=%0h got=no_ack expected=ack", i, a);
    end
  endtask

  task automatic hold_req(input int i, input logic w, input logic [7:0] a, input logic [7:0] d0,
                          input logic [7:0] d1, input int ncyc, output int nacks, output int r0,
                          output int r1, output int nbusy_lo);
    nacks = 0; r0 = -1; r1 = -1; nbusy_lo = 0;
    @(negedge clk);
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (ack[i] === 1'b1) begin
        if (nacks == 0) r0 = c;
        else if (nacks == 1) r1 = c;
        nacks++;
        wdata[i] = d1;
      end
      if (busy[i] !== 1'b1) nbusy_lo++;
    end
    req[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  logic [7:0] rd;
  logic       er;
  int         lat, nacks, r0, r1, nlo, acks_seen;

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 8'h00; wdata[i] = 8'h00;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("rst_ack",  1, 32'(ack[1]),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("post_rst_busy", 1, 32'(busy[1]), 32'd0);

    // Two wait states: write then read back.
    txn(0, 1'b1, 8'h10, 8'hA5, rd, er, lat);
    chk("w2_wr_lat", 0, 32'(lat), 32'd3);
    chk("w2_wr_err", 0, 32'(er), 32'd0);
    txn(0, 1'b0, 8'h10, 8'h00, rd, er, lat);
    chk("w2_rd_lat",  0, 32'(lat), 32'd3);
    chk("w2_rd_data", 0, 32'(rd), 32'hA5);
    chk("w2_rd_err",  0, 32'(er), 32'd0);

    // Zero wait states: back-to-back writes with req held high.
    hold_req(1, 1'b1, 8'h05, 8'h01, 8'h02, 4, nacks, r0, r1, nlo);
    chk("w0_nacks", 1, 32'(nacks), 32'd2);
    chk("w0_ack0",  1, 32'(r0), 32'd0);
    chk("w0_ack1",  1, 32'(r1), 32'd2);
    repeat (2) @(negedge clk);
    txn(1, 1'b0, 8'h05, 8'h00, rd, er, lat);
    chk("w0_rd_lat",  1, 32'(lat), 32'd1);
    chk("w0_rd_data", 1, 32'(rd), 32'h02);

    // Two wait states, req held for 10 cycles.
    hold_req(0, 1'b1, 8'h30, 8'h40, 8'h41, 10, nacks, r0, r1, nlo);
    chk("w2_hold_nacks", 0, 32'(nacks), 32'd2);
    chk("w2_hold_ack0",  0, 32'(r0 + 1), 32'd3);
    chk("w2_hold_ack1",  0, 32'(r1 + 1), 32'd7);
    chk("w2_hold_idle",  0, 32'(nlo), 32'd2);
    repeat (6) @(negedge clk);

    // Out of range.
    txn(0, 1'b1, 8'h48, 8'h5A, rd, er, lat);
    txn(0, 1'b0, 8'hC8, 8'h00, rd, er, lat);
    chk("oor_rd_err",  0, 32'(er), 32'd1);
    chk("oor_rd_data", 0, 32'(rd), 32'd0);
    txn(0, 1'b1, 8'hC8, 8'hEE, rd, er, lat);
    chk("oor_wr_err", 0, 32'(er), 32'd1);
    txn(0, 1'b0, 8'h48, 8'h00, rd, er, lat);
    chk("in_rd_data", 0, 32'(rd), 32'h5A);
    chk("in_rd_err",  0, 32'(er), 32'd0);
    txn(1, 1'b0, 8'hFF, 8'h00, rd, er, lat);
    chk("w0_oor_err", 1, 32'(er), 32'd1);
    chk("w0_oor_lat", 1, 32'(lat), 32'd1);

    // Reset during WAIT drops the write.
    txn(0, 1'b1, 8'h20, 8'h77, rd, er, lat);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h20; wdata[0] = 8'h3C;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req[0] = 1'b0;
    #1;
    chk("async_rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("async_rst_ack",  0, 32'(ack[0]),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    acks_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ack[0] === 1'b1) acks_seen++;
    end
    chk("rst_drop_acks", 0, 32'(acks_seen), 32'd0);
    txn(0, 1'b0, 8'h20, 8'h00, rd, er, lat);
    chk("rst_no_commit", 0, 32'(rd), 32'h77);
    txn(0, 1'b1, 8'h20, 8'h11, rd, er, lat);
    txn(0, 1'b0, 8'h20, 8'h00, rd, er, lat);
    chk("rst_rewrite", 0, 32'(rd), 32'h11);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/proc_mem_responder.md
Name: proc_mem_responder

Overview:
- Memory-side responder for the processor's load/store bus. The processor issues requests and this block answers them.
- Holds a synchronous single-port data store and adds a configurable number of wait states.
- Returns read data or a write acknowledge through a single-cycle ack, and flags accesses outside the store.
- Instantiated beside the processor in the top-level and test harness, sharing its clock and reset.

Parameters:
- ADDR_W, 8, width of the request address.
- DATA_W, 8, width of read and write data.
- DEPTH, 200, number of implemented words. Addresses at or above DEPTH are out of range.
- WAIT_CYCLES, 2, extra cycles inserted between request capture and ack. Legal range is 0 to 15.

Ports:
- clk_in  input  1  clock; all state changes on its rising edge.
- rst_in  input  1  asynchronous active-low reset.
- req_in  input  1  request valid from the processor.
- we_in  input  1  1 = write, 0 = read. Sampled with req_in.
- addr_in  input  ADDR_W  word address. Sampled with req_in.
- wdata_in  input  DATA_W  write data. Sampled with req_in.
- rdata_out  output  DATA_W  read data. Valid only while ack_out = 1.
- ack_out  output  1  one-cycle completion pulse.
- err_out  output  1  out-of-range flag. Asserted only together with ack_out.
- busy_out  output  1  high in every non-IDLE state.

Behaviour:
- Reset (rst_in = 0, asynchronous):
  - State goes to IDLE and the wait counter clears.
  - rdata_out, ack_out, err_out and busy_out all become 0.
  - Latched request registers clear.
  - Store contents are not reset; they are undefined until written.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with req_in = 1, latch we_in, addr_in and wdata_in.
  - Go to WAIT, or directly to RESP when WAIT_CYCLES = 0, and load the counter with WAIT_CYCLES-1.
  - With req_in = 0, stay in IDLE.
- WAIT:
  - Decrement the counter each edge.
  - On the edge where the counter is 0, go to RESP.
  - Inputs are ignored while in this state.
- RESP:
  - Lasts exactly one cycle: ack_out = 1, busy_out = 1, then return to IDLE on the next edge.
  - A write commits to the store on the edge entering RESP.
  - A read performs the store read on the same edge, so rdata_out is registered and valid for the whole RESP cycle.
- Latency: a request sampled at edge k produces ack_out high in the cycle after edge k+WAIT_CYCLES, i.e. WAIT_CYCLES+1 cycles after capture.
- Out of range (addr >= DEPTH):
  - ack_out = 1 and err_out = 1.
  - No store write takes place.
  - rdata_out = 0.
- Outside RESP: rdata_out = 0, err_out = 0 and ack_out = 0. These are registered outputs, not held values.
- Handshake:
  - The processor keeps req_in high until it sees ack_out.
  - req_in high during WAIT or RESP is not a new request.
  - The first IDLE cycle with req_in = 1 starts the next transaction, so back-to-back throughput is one per WAIT_CYCLES+2 cycles.
- Read-after-write to the same address in consecutive transactions returns the new data.
- Reset mid-operation: the transaction is dropped and no ack is issued. A write that was still in WAIT is not committed.
- Width rules:
  - The compare against DEPTH uses the full ADDR_W address.
  - The store is indexed by $clog2(DEPTH) bits, used only when in range.

Decomposition:
- Shared package proc_bus_pkg holds:
  - the ADDR_W and DATA_W defaults, shared with the processor load/store unit;
  - the state enum {IDLE, WAIT, RESP};
  - the counter width constant of 4 bits.
- One sub-module, proc_mem_array: single-port synchronous RAM with write-enable, address and data-in ports, and a registered data-out.
- The FSM, counter and range check stay in proc_mem_responder.

Test Plan:
- Reset with rst_in = 0 for 3 cycles, then release → all outputs 0 and busy_out = 0. Reset asserted in the middle of a clock cycle must clear the outputs immediately, without waiting for an edge.
- WAIT_CYCLES = 2: write 8'hA5 to addr 8'h10, then read addr 8'h10 → ack_out pulses exactly 3 cycles after each capture edge, and the read returns rdata_out = 8'hA5 with err_out = 0.
- WAIT_CYCLES = 0: back-to-back writes of 8'h01 and 8'h02 to addr 8'h05, then a read → one ack per 2 cycles and rdata_out = 8'h02.
- Read addr 8'hC8 (200 = DEPTH) → ack_out = 1, err_out = 1, rdata_out = 0. A later read of addr 8'h48 is unaffected by any aliasing.
- Write 8'h3C to addr 8'h20, then drop rst_in to 0 while in WAIT and release → no ack_out pulse appears. Then write 8'h11 to addr 8'h20 and read it back → returns 8'h11.
- Hold req_in high continuously for 10 cycles with WAIT_CYCLES = 2 → exactly 2 acks, at cycles 3 and 7 relative to the first capture, and busy_out is low only in the IDLE capture cycles.
